// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of the frame RAM read port among
// the pixel-pipeline requesters (Pac-Man, four ghosts, maze fetch). Grants
// one read per clock and returns each color tagged with its requester ID
// plus a transparency flag for sprite-over-maze compositing.

module sprite_rom_arbiter #(
  parameter int N = 6,
  parameter int ADDR_W = 18,
  parameter int DATA_W = 24,
  parameter int MEM_LAT = 1,
  parameter logic [DATA_W-1:0] KEY_COLOR = 24'h000000
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [N-1:0]        req,
  input  logic [N*ADDR_W-1:0] req_addr,
  output logic [N-1:0]        gnt,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                rd_valid,
  output logic [2:0]          rd_id,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_transparent
);

  logic [2:0]             ptr;
  logic [N-1:0]           eligible;
  logic                   found;
  logic [2:0]             win_idx;
  logic [ADDR_W-1:0]      win_addr;
  logic [N-1:0]           gnt_next;
  logic [2:0]             ptr_next;
  logic [MEM_LAT:0]       pipe_valid;
  logic [MEM_LAT:0][2:0]  pipe_id;

  // Search from ptr, wrapping modulo N; a requester granted last edge is masked.
  always_comb begin
    int idx;
    eligible = req & ~gnt;
    found    = 1'b0;
    win_idx  = '0;
    win_addr = '0;
    idx      = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!found && eligible[idx]) begin
        found    = 1'b1;
        win_idx  = 3'(idx);
        win_addr = req_addr[idx*ADDR_W +: ADDR_W];
      end
    end
  end

  // One-hot grant for the winner and the pointer slot just past it.
  always_comb begin
    gnt_next = '0;
    if (found) gnt_next[win_idx] = 1'b1;
    if (int'(win_idx) + 1 >= N) ptr_next = 3'd0;
    else                        ptr_next = win_idx + 3'd1;
  end

  // Registered grant, read strobe and address; address and pointer hold when idle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      gnt      <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      ptr      <= '0;
    end else begin
      gnt    <= gnt_next;
      mem_rd <= found;
      if (found) begin
        mem_addr <= win_addr;
        ptr      <= ptr_next;
      end
    end
  end

  // Return tag pipeline tracks each issued read until its data arrives.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pipe_valid <= '0;
      pipe_id    <= '0;
    end else begin
      pipe_valid[0] <= found;
      pipe_id[0]    <= win_idx;
      for (int i = 1; i <= MEM_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
      end
    end
  end

  // Capture the returned color with its owner tag and transparency flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_valid       <= 1'b0;
      rd_id          <= '0;
      rd_data        <= '0;
      rd_transparent <= 1'b0;
    end else begin
      rd_valid <= pipe_valid[MEM_LAT];
      rd_id    <= pipe_id[MEM_LAT];
      if (pipe_valid[MEM_LAT]) begin
        rd_data        <= mem_data;
        rd_transparent <= (mem_data == KEY_COLOR);
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: drives two arbiters (read latency 1 and 3) from the
// same requesters; a reference model predicts grants and queues the expected
// returns, which independent monitors match against each rd_valid pulse.

module tb_sprite_rom_arbiter;

  localparam int N = 6;
  localparam int AW = 18;
  localparam int DW = 24;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct {
    int          id;
    logic [23:0] data;
    logic        transp;
    int          cyc;
  } resp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req;
  logic [AW-1:0] addr_of [N];
  logic [N*AW-1:0] req_addr;

  logic [N-1:0]  gnt_a, gnt_b;
  logic          mem_rd_a, mem_rd_b;
  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic [DW-1:0] mem_data_a, mem_data_b;
  logic          rd_valid_a, rd_valid_b;
  logic [2:0]    rd_id_a, rd_id_b;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          rd_transparent_a, rd_transparent_b;

  logic [DW-1:0] mem_pipe_a [LAT_A];
  logic [DW-1:0] mem_pipe_b [LAT_B];

  int cycle = 0;
  int errors = 0;
  int checks = 0;

  int          m_ptr;
  logic [N-1:0] m_prev;
  logic [N-1:0] exp_gnt;
  logic         exp_rd;
  logic [AW-1:0] exp_addr;
  resp_t q_a[$];
  resp_t q_b[$];

  always #5 clk = ~clk;

  // Pack the per-requester addresses onto the flat address bus.
  always_comb begin
    req_addr = '0;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr_of[i];
  end

  // Frame RAM contents: a few fixed sprite colors, key color on every 8th word.
  function automatic logic [23:0] mem_color(input logic [17:0] a);
    case (a)
      18'h00105: return 24'hFFB8FF;
      18'h00010: return 24'h000000;
      18'h00550: return 24'h2121DE;
      default: begin
        if (a[2:0] == 3'd0) return 24'h000000;
        return {a[5:0], a} ^ 24'h5A5A5A;
      end
    endcase
  endfunction

  sprite_rom_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_A), .KEY_COLOR(24'h000000)) dut_a (
    .Clk(clk), .Reset_n(reset_n), .req(req), .req_addr(req_addr), .gnt(gnt_a),
    .mem_rd(mem_rd_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a), .rd_valid(rd_valid_a),
    .rd_id(rd_id_a), .rd_data(rd_data_a), .rd_transparent(rd_transparent_a));

  sprite_rom_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_B), .KEY_COLOR(24'h000000)) dut_b (
    .Clk(clk), .Reset_n(reset_n), .req(req), .req_addr(req_addr), .gnt(gnt_b),
    .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b), .rd_valid(rd_valid_b),
    .rd_id(rd_id_b), .rd_data(rd_data_b), .rd_transparent(rd_transparent_b));

  // Frame RAM models: data appears LAT clocks after the read strobe edge; filler otherwise.
  always @(posedge clk) begin
    mem_pipe_a[0] <= mem_rd_a ? mem_color(mem_addr_a) : 24'hDEAD5A;
    for (int i = 1; i < LAT_A; i++) mem_pipe_a[i] <= mem_pipe_a[i-1];
    mem_pipe_b[0] <= mem_rd_b ? mem_color(mem_addr_b) : 24'hDEAD5A;
    for (int i = 1; i < LAT_B; i++) mem_pipe_b[i] <= mem_pipe_b[i-1];
  end
  assign mem_data_a = mem_pipe_a[LAT_A-1];
  assign mem_data_b = mem_pipe_b[LAT_B-1];

  // Edge counter used to time expected returns.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
    end
  endtask

  task automatic compareResp(input string lane, input resp_t e, input logic [2:0] id,
                             input logic [23:0] d, input logic t);
    check({lane, "_rd_id"}, 32'(id), 32'(e.id));
    check({lane, "_rd_data"}, 32'(d), 32'(e.data));
    check({lane, "_rd_transparent"}, 32'(t), 32'(e.transp));
  endtask

  // Monitor for the latency-1 arbiter: every pulse must match the oldest expected return.
  always @(negedge clk) begin
    if (reset_n) begin
      while (q_a.size() > 0 && q_a[0].cyc < cycle) begin
        checks++; errors++;
        $display("[TB] FAIL A_missing_rd_valid at cycle %0d: got none, expected id %0d", cycle, q_a[0].id);
        void'(q_a.pop_front());
      end
      if (rd_valid_a) begin
        if (q_a.size() == 0 || q_a[0].cyc != cycle) begin
          checks++; errors++;
          $display("[TB] FAIL A_unexpected_rd_valid at cycle %0d: got id %0d, expected no pulse", cycle, rd_id_a);
        end else begin
          compareResp("A", q_a.pop_front(), rd_id_a, rd_data_a, rd_transparent_a);
        end
      end
    end
  end

  // Monitor for the latency-3 arbiter.
  always @(negedge clk) begin
    if (reset_n) begin
      while (q_b.size() > 0 && q_b[0].cyc < cycle) begin
        checks++; errors++;
        $display("[TB] FAIL B_missing_rd_valid at cycle %0d: got none, expected id %0d", cycle, q_b[0].id);
        void'(q_b.pop_front());
      end
      if (rd_valid_b) begin
        if (q_b.size() == 0 || q_b[0].cyc != cycle) begin
          checks++; errors++;
          $display("[TB] FAIL B_unexpected_rd_valid at cycle %0d: got id %0d, expected no pulse", cycle, rd_id_b);
        end else begin
          compareResp("B", q_b.pop_front(), rd_id_b, rd_data_b, rd_transparent_b);
        end
      end
    end
  end

  task automatic modelReset();
    m_ptr    = 0;
    m_prev   = '0;
    exp_gnt  = '0;
    exp_rd   = 1'b0;
    exp_addr = '0;
    q_a.delete();
    q_b.delete();
  endtask

  // Reference rule: first requester at or after the pointer that is asking and
  // was not granted on the previous edge; pointer moves just past the winner.
  task automatic predict();
    int w;
    resp_t e;
    w = -1;
    for (int off = 0; off < N; off++) begin
      int idx;
      idx = (m_ptr + off) % N;
      if (w < 0 && req[idx] && !m_prev[idx]) w = idx;
    end
    exp_gnt = '0;
    if (w >= 0) begin
      exp_gnt[w] = 1'b1;
      exp_rd     = 1'b1;
      exp_addr   = addr_of[w];
      m_ptr      = (w + 1) % N;
      e.id       = w;
      e.data     = mem_color(addr_of[w]);
      e.transp   = (e.data == 24'h000000);
      e.cyc      = cycle + 2 + LAT_A;
      q_a.push_back(e);
      e.cyc      = cycle + 2 + LAT_B;
      q_b.push_back(e);
    end else begin
      exp_rd = 1'b0;
    end
    m_prev = exp_gnt;
  endtask

  task automatic checkOutput();
    check("A_gnt", 32'(gnt_a), 32'(exp_gnt));
    check("B_gnt", 32'(gnt_b), 32'(exp_gnt));
    check("A_mem_rd", 32'(mem_rd_a), 32'(exp_rd));
    check("B_mem_rd", 32'(mem_rd_b), 32'(exp_rd));
    check("A_mem_addr", 32'(mem_addr_a), 32'(exp_addr));
    check("B_mem_addr", 32'(mem_addr_b), 32'(exp_addr));
  endtask

  task automatic checkReset();
    check("A_reset_gnt", 32'(gnt_a), 32'd0);
    check("B_reset_gnt", 32'(gnt_b), 32'd0);
    check("A_reset_mem_rd", 32'(mem_rd_a), 32'd0);
    check("B_reset_mem_rd", 32'(mem_rd_b), 32'd0);
    check("A_reset_mem_addr", 32'(mem_addr_a), 32'd0);
    check("B_reset_mem_addr", 32'(mem_addr_b), 32'd0);
    check("A_reset_rd_valid", 32'(rd_valid_a), 32'd0);
    check("B_reset_rd_valid", 32'(rd_valid_b), 32'd0);
    check("A_reset_rd_id", 32'(rd_id_a), 32'd0);
    check("B_reset_rd_id", 32'(rd_id_b), 32'd0);
    check("A_reset_rd_data", 32'(rd_data_a), 32'd0);
    check("B_reset_rd_data", 32'(rd_data_b), 32'd0);
    check("A_reset_rd_transparent", 32'(rd_transparent_a), 32'd0);
    check("B_reset_rd_transparent", 32'(rd_transparent_b), 32'd0);
  endtask

  task automatic stepCycle();
    predict();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [N-1:0] r);
    req = r;
  endtask

  // Randomised requesters: hold until granted, sometimes re-request or withdraw.
  task automatic randomTraffic(input int cycles);
    repeat (cycles) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && exp_gnt[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 9) < 4) begin
            addr_of[i] = 18'($urandom_range(0, 255));
            req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 19) == 0) begin
          req[i] = 1'b0;
        end
      end
      stepCycle();
    end
  endtask

  initial begin
    reset_n = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) addr_of[i] = 18'($urandom_range(1, 255) * 8 + 3);
    addr_of[3] = 18'h00105;
    #1;

    // Reset held with every requester asking.
    reset_n = 1'b0;
    applyStimulus('1);
    modelReset();
    repeat (3) begin
      @(posedge clk);
      #1;
      checkReset();
    end
    reset_n = 1'b1;
    stepCycle();

    // Lone requester 3: granted every other cycle.
    applyStimulus(6'b001000);
    repeat (10) stepCycle();

    // Full contention.
    applyStimulus('0);
    repeat (3) stepCycle();
    for (int i = 0; i < N; i++) addr_of[i] = 18'($urandom_range(0, 1023));
    applyStimulus('1);
    repeat (14) stepCycle();

    // Transparency: key color for requester 1, opaque blue for requester 5.
    applyStimulus('0);
    repeat (4) stepCycle();
    addr_of[1] = 18'h00010;
    addr_of[5] = 18'h00550;
    applyStimulus(6'b100010);
    repeat (4) begin
      stepCycle();
      req &= ~exp_gnt;
    end
    repeat (4) stepCycle();

    // Pointer parked at 4 by serving requester 3, then 4 and 0 compete.
    addr_of[3] = 18'($urandom_range(0, 1023));
    applyStimulus(6'b001000);
    repeat (3) begin
      stepCycle();
      req &= ~exp_gnt;
    end
    addr_of[4] = 18'($urandom_range(0, 1023));
    addr_of[0] = 18'($urandom_range(0, 1023));
    applyStimulus(6'b010001);
    repeat (4) begin
      stepCycle();
      req &= ~exp_gnt;
    end
    repeat (6) stepCycle();

    // Random traffic.
    randomTraffic(400);

    // Reset one cycle after a grant: its read must never return.
    applyStimulus('0);
    repeat (8) stepCycle();
    addr_of[2] = 18'h00777;
    applyStimulus(6'b000100);
    stepCycle();
    applyStimulus('0);
    stepCycle();
    reset_n = 1'b0;
    modelReset();
    repeat (3) begin
      @(posedge clk);
      #1;
      checkReset();
    end
    reset_n = 1'b1;
    repeat (8) stepCycle();
    applyStimulus('1);
    stepCycle();
    applyStimulus('0);
    repeat (10) stepCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
